// File: rtl/vram_arbiter.sv
// ----------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port synchronous VRAM (16-bit words, 1-cycle read latency)
// between the raster fetch (absolute priority, fixed 2-cycle read latency) and
// a req/ack CPU bus. CPU accesses are deferred around video reads. Cycles in
// which a pending CPU request is blocked by video are counted (saturating).
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   vid_rd, vid_addr   video read strobe (1 cycle, >=2 cycles apart) + address
//   vid_dout           video read data, held until the next video read lands
//   cpu_req/we/addr    CPU request level, direction and word address
//   cpu_be, cpu_wdata  CPU write byte enables {hi,lo} and write data
//   cpu_rdata          CPU read data, valid with cpu_ack and held afterwards
//   cpu_ack            one-cycle completion pulse
//   ram_addr/we/be     RAM control (combinational mux)
//   ram_wdata          RAM write data (always the CPU write data)
//   ram_rdata          RAM read data for the address presented last cycle
//   conflict_cnt       blocked-cycle counter, saturates at all-ones
// ----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int AW    = 14,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vid_rd,
    input  logic [AW-1:0]    vid_addr,
    output logic [15:0]      vid_dout,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [1:0]       cpu_be,
    input  logic [15:0]      cpu_wdata,
    output logic [15:0]      cpu_rdata,
    output logic             cpu_ack,
    output logic [AW-1:0]    ram_addr,
    output logic             ram_we,
    output logic [1:0]       ram_be,
    output logic [15:0]      ram_wdata,
    input  logic [15:0]      ram_rdata,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RDWAIT = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t state;
    logic   vid_pend_p1;
    logic   grant;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Reset gates the grant so a write presented during reset never reaches the RAM.
    assign grant = (state == IDLE) && cpu_req && !vid_rd && !reset;

    always_comb begin
        ram_addr = cpu_addr;
        ram_we   = 1'b0;
        ram_be   = 2'b00;
        if (vid_rd) begin
            ram_addr = vid_addr;
        end else if (grant) begin
            ram_we = cpu_we;
            ram_be = cpu_we ? cpu_be : 2'b00;
        end
    end

    assign ram_wdata = cpu_wdata;

    // ACK lasts exactly one cycle, so the ack is a direct decode of the state register.
    assign cpu_ack = (state == ACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            vid_pend_p1  <= 1'b0;
            vid_dout     <= '0;
            cpu_rdata    <= '0;
            conflict_cnt <= '0;
        end else begin
            // Stage p1: RAM returns data for the video address issued last cycle.
            vid_pend_p1 <= vid_rd;
            if (vid_pend_p1) begin
                vid_dout <= ram_rdata;
            end

            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        if (vid_rd) begin
                            conflict_cnt <= sat_inc(conflict_cnt);
                        end else begin
                            state <= cpu_we ? ACK : RDWAIT;
                        end
                    end
                end
                // The RAM is pipelined, so a video read issued now does not
                // disturb the CPU data returning this cycle.
                RDWAIT: begin
                    cpu_rdata <= ram_rdata;
                    state     <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

    localparam int AW    = 14;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             vid_rd;
    logic [AW-1:0]    vid_addr;
    logic [15:0]      vid_dout;
    logic             cpu_req;
    logic             cpu_we;
    logic [AW-1:0]    cpu_addr;
    logic [1:0]       cpu_be;
    logic [15:0]      cpu_wdata;
    logic [15:0]      cpu_rdata;
    logic             cpu_ack;
    logic [AW-1:0]    ram_addr;
    logic             ram_we;
    logic [1:0]       ram_be;
    logic [15:0]      ram_wdata;
    logic [15:0]      ram_rdata;
    logic [CNT_W-1:0] conflict_cnt;

    int n_vec = 0;
    int n_bad = 0;
    bit vid_done = 1'b0;

    vram_arbiter #(.AW(AW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .vid_rd       (vid_rd),
        .vid_addr     (vid_addr),
        .vid_dout     (vid_dout),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_be       (cpu_be),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_ack      (cpu_ack),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_be       (ram_be),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    // VRAM model: 1-cycle synchronous read, byte-enabled write.
    // Contents start as addr ^ 0x5A5A, except word 0x0123 = 0xA5C3.
    logic [15:0] mem [0:(1<<AW)-1];
    bit          mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < (1 << AW); i++)
                mem[i] <= (i == 'h123) ? 16'hA5C3 : (16'(i) ^ 16'h5A5A);
            mem_ready <= 1'b1;
        end else if (ram_we) begin
            if (ram_be[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
            if (ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
        end
        ram_rdata <= mem[ram_addr];
    end

    function automatic logic [15:0] init_val(input logic [AW-1:0] a);
        return {2'b00, a} ^ 16'h5A5A;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One CPU transaction; optionally fires a video read in the request cycle.
    task automatic cpu_xfer(input bit we, input logic [AW-1:0] a, input logic [1:0] be,
                            input logic [15:0] d, input int exp_lat, input logic [15:0] exp_rd,
                            input bit with_vid, input logic [AW-1:0] va, input string nm);
        int lat;
        lat       = 0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_be    = be;
        cpu_wdata = d;
        if (with_vid) begin
            vid_rd   = 1'b1;
            vid_addr = va;
        end
        for (int c = 1; c <= 8; c++) begin
            tick();
            vid_rd = 1'b0;
            if (cpu_ack) begin
                lat = c;
                break;
            end
        end
        chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        if (!we) chk({nm, "_rdata"}, 32'(cpu_rdata), 32'(exp_rd));
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        tick();
        chk({nm, "_ack_pulse"}, 32'(cpu_ack), 32'(0));
    endtask

    typedef struct {
        bit          we;
        logic [13:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [AW-1:0] va;
        int            exp_cnt;

        tbl[0]  = '{1'b1, 14'h0040, 2'b11, 16'hBEEF, 16'h0000, 1};
        tbl[1]  = '{1'b0, 14'h0040, 2'b00, 16'h0000, 16'hBEEF, 2};
        tbl[2]  = '{1'b1, 14'h0040, 2'b01, 16'h1234, 16'h0000, 1};
        tbl[3]  = '{1'b0, 14'h0040, 2'b00, 16'h0000, 16'hBE34, 2};
        tbl[4]  = '{1'b1, 14'h0041, 2'b10, 16'hABCD, 16'h0000, 1};
        tbl[5]  = '{1'b0, 14'h0041, 2'b00, 16'h0000, 16'hAB1B, 2};
        tbl[6]  = '{1'b0, 14'h0050, 2'b00, 16'h0000, 16'h5A0A, 2};
        tbl[7]  = '{1'b1, 14'h3FFF, 2'b11, 16'h0F0F, 16'h0000, 1};
        tbl[8]  = '{1'b0, 14'h3FFF, 2'b00, 16'h0000, 16'h0F0F, 2};
        tbl[9]  = '{1'b1, 14'h0000, 2'b00, 16'hFFFF, 16'h0000, 1};
        tbl[10] = '{1'b0, 14'h0000, 2'b00, 16'h0000, 16'h5A5A, 2};

        reset = 1'b1; vid_rd = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("por_vid_dout", 32'(vid_dout), 32'(0));
        chk("por_cpu_rdata", 32'(cpu_rdata), 32'(0));
        chk("por_cpu_ack", 32'(cpu_ack), 32'(0));
        chk("por_conflict", 32'(conflict_cnt), 32'(0));
        chk("por_ram_we", 32'(ram_we), 32'(0));
        tick();

        // Load non-zero values into cpu_rdata and vid_dout before the mid-transaction reset.
        cpu_xfer(1'b0, 14'h0040, 2'b00, 16'h0, 2, 16'h5A1A, 1'b0, '0, "pre_rd");

        vid_rd = 1'b1; vid_addr = 14'h0123;
        #1;
        chk("vid_ram_addr", 32'(ram_addr), 32'h123);
        chk("vid_ram_we", 32'(ram_we), 32'(0));
        tick(); vid_rd = 1'b0;
        chk("vid_T1_old", 32'(vid_dout), 32'(0));
        tick();
        chk("vid_T2", 32'(vid_dout), 32'hA5C3);
        tick(); tick();
        chk("vid_held", 32'(vid_dout), 32'hA5C3);

        // Reset while in RDWAIT; a write presented during reset must not reach the RAM.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0050;
        tick();
        reset = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_wdata = 16'hDEAD;
        #1;
        chk("rst1_ram_we", 32'(ram_we), 32'(0));
        tick();
        chk("rst2_ack", 32'(cpu_ack), 32'(0));
        chk("rst2_ram_we", 32'(ram_we), 32'(0));
        tick();
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        chk("rst_ack", 32'(cpu_ack), 32'(0));
        chk("rst_vid_dout", 32'(vid_dout), 32'(0));
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
        chk("rst_conflict", 32'(conflict_cnt), 32'(0));
        tick();
        chk("rst_after_ack", 32'(cpu_ack), 32'(0));

        for (int i = 0; i < 11; i++)
            cpu_xfer(tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, tbl[i].lat,
                     tbl[i].exp, 1'b0, '0, $sformatf("vec%0d", i));

        // CPU read requested in the same cycle as a video read.
        vid_rd = 1'b1; vid_addr = 14'h0123;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0040;
        #1;
        chk("con_T0_addr", 32'(ram_addr), 32'h123);
        tick(); vid_rd = 1'b0;
        #1;
        chk("con_T1_cnt", 32'(conflict_cnt), 32'(1));
        chk("con_T1_addr", 32'(ram_addr), 32'h40);
        chk("con_T1_ack", 32'(cpu_ack), 32'(0));
        tick();
        chk("con_T2_vid", 32'(vid_dout), 32'hA5C3);
        chk("con_T2_ack", 32'(cpu_ack), 32'(0));
        tick();
        chk("con_T3_ack", 32'(cpu_ack), 32'(1));
        chk("con_T3_rdata", 32'(cpu_rdata), 32'hBE34);
        cpu_req = 1'b0;
        tick();

        // 19 more contended reads: counter reaches 15 and stays there.
        for (int i = 1; i < 20; i++) begin
            va = 14'h1000 + 14'(i);
            cpu_xfer(1'b0, 14'h3FFF, 2'b00, 16'h0, 3, 16'h0F0F, 1'b1, va, $sformatf("sat%0d", i));
            exp_cnt = (i + 1 > 15) ? 15 : i + 1;
            chk($sformatf("sat%0d_cnt", i), 32'(conflict_cnt), 32'(exp_cnt));
            chk($sformatf("sat%0d_vid", i), 32'(vid_dout), 32'(init_val(va)));
        end

        // Video every 2 cycles while the CPU streams writes and readbacks.
        fork
            begin : video_proc
                logic [AW-1:0] a;
                for (int k = 0; k < 1000; k++) begin
                    a = 14'h1000 + 14'($urandom_range(0, 255));
                    vid_rd = 1'b1; vid_addr = a;
                    tick();
                    vid_rd = 1'b0;
                    tick();
                    chk("stress_vid", 32'(vid_dout), 32'(init_val(a)));
                end
                vid_done = 1'b1;
            end
            begin : cpu_proc
                logic [15:0] shadow [64];
                int          j;
                int          idx;
                bit          wr;
                bit          got;
                logic [15:0] d;
                j = 0;
                while (!vid_done) begin
                    idx = (j >> 1) % 64;
                    wr  = (j % 2) == 0;
                    d   = 16'($urandom_range(0, 65535));
                    if (wr) shadow[idx] = d;
                    cpu_req = 1'b1; cpu_we = wr; cpu_be = 2'b11; cpu_wdata = d;
                    cpu_addr = 14'h2000 + 14'(idx);
                    got = 1'b0;
                    for (int c = 0; c < 8; c++) begin
                        tick();
                        if (cpu_ack) begin
                            got = 1'b1;
                            break;
                        end
                    end
                    chk("stress_ack", 32'(got), 32'(1));
                    if (!wr) chk("stress_rdata", 32'(cpu_rdata), 32'(shadow[idx]));
                    cpu_req = 1'b0; cpu_we = 1'b0;
                    tick();
                    j++;
                end
            end
        join

        chk("sat_final", 32'(conflict_cnt), 32'(15));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
